// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with an IDLE/RUN/EXPIRED FSM and a one-cycle Done pulse.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value after expiry.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Decrease,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_value;
`endif

  // Busy and Done are registered next to the state so they always equal (state==RUN) and (state==EXPIRED).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Count <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_value <= '0;
`endif
    end else if (Abort) begin
      state <= IDLE;
      Count <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else if (Load) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_value <= LoadValue;
`endif
      if (LoadValue != '0) begin
        state <= RUN;
        Count <= LoadValue;
        Busy  <= 1'b1;
        Done  <= 1'b0;
      end else begin
        state <= EXPIRED;
        Count <= '0;
        Busy  <= 1'b0;
        Done  <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          Busy <= 1'b0;
          Done <= 1'b0;
        end
        RUN: begin
          // A zero Count in RUN is unreachable, but it expires rather than wrapping.
          if (Decrease) begin
            if (Count > ONE) begin
              Count <= Count - ONE;
            end else begin
              state <= EXPIRED;
              Count <= '0;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        EXPIRED: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (reload_value != '0) begin
            state <= RUN;
            Count <= reload_value;
            Busy  <= 1'b1;
            Done  <= 1'b0;
          end else begin
            state <= IDLE;
            Count <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
          end
`else
          state <= IDLE;
          Count <= '0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          Count <= '0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus randomized stimulus checked against a behavioural model.
module tb_countdown_timer;

  localparam int WIDTH = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN = 1;
  localparam int PH_EXPIRED = 2;

  logic             Clock;
  logic             Reset;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             Decrease;
  logic             Abort;
  logic [WIDTH-1:0] Count;
  logic             Busy;
  logic             Done;

  int n_checks = 0;
  int n_fail = 0;

  int m_count = 0;
  int m_phase = PH_IDLE;
  int m_reload = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Load(Load),
    .LoadValue(LoadValue),
    .Decrease(Decrease),
    .Abort(Abort),
    .Count(Count),
    .Busy(Busy),
    .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drives one cycle of inputs, advances the behavioural model on the edge, then samples 1 time unit later.
  task automatic tick(input bit rst, input bit ld, input int lv, input bit dec, input bit ab);
    Reset = rst;
    Load = ld;
    LoadValue = WIDTH'(lv);
    Decrease = dec;
    Abort = ab;
    @(posedge Clock);
    if (rst) begin
      m_count = 0;
      m_phase = PH_IDLE;
      m_reload = 0;
    end else if (ab) begin
      m_count = 0;
      m_phase = PH_IDLE;
    end else if (ld) begin
      m_reload = lv;
      m_count = lv;
      m_phase = (lv == 0) ? PH_EXPIRED : PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (dec) begin
        m_count = (m_count > 0) ? m_count - 1 : 0;
        if (m_count == 0) m_phase = PH_EXPIRED;
      end
    end else if (m_phase == PH_EXPIRED) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      m_count = m_reload;
      m_phase = (m_reload != 0) ? PH_RUN : PH_IDLE;
`else
      m_count = 0;
      m_phase = PH_IDLE;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 7, 1, 0);
    n_checks++;
    if ({Count, Busy, Done} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset: got Count=%0d Busy=%0b Done=%0b, expected Count=0 Busy=0 Done=0", Count, Busy, Done);
    end
  endtask

  task automatic test_decrease_held();
    logic [5:0] exp [5];
`ifdef COUNTDOWN_AUTORELOAD_EN
    exp = '{{4'd3, 1'b1, 1'b0}, {4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd3, 1'b1, 1'b0}};
`else
    exp = '{{4'd3, 1'b1, 1'b0}, {4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0}};
`endif
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) tick(0, 1, 3, 0, 0);
      else tick(0, 0, 0, 1, 0);
      n_checks++;
      if ({Count, Busy, Done} !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL decrease_held step %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, exp[i][5:2], exp[i][1], exp[i][0]);
      end
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_decrease_toggle();
    logic [5:0] exp [5];
    exp = '{{4'd5, 1'b1, 1'b0}, {4'd4, 1'b1, 1'b0}, {4'd4, 1'b1, 1'b0}, {4'd3, 1'b1, 1'b0}, {4'd3, 1'b1, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) tick(0, 1, 5, 0, 0);
      else tick(0, 0, 0, (i % 2) == 1, 0);
      n_checks++;
      if ({Count, Busy, Done} !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL decrease_toggle step %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, exp[i][5:2], exp[i][1], exp[i][0]);
      end
    end
    tick(0, 0, 0, 0, 1);
  endtask

  // Cancels a countdown at Count=2 with Abort (pass 0) and with Reset (pass 1); Decrease is held to tempt an expiry.
  task automatic test_abort_and_reset();
    logic [5:0] exp [5];
    exp = '{{4'd4, 1'b1, 1'b0}, {4'd3, 1'b1, 1'b0}, {4'd2, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        case (i)
          0: tick(0, 1, 4, 0, 0);
          1, 2: tick(0, 0, 0, 1, 0);
          3: tick(pass == 1, 0, 0, 1, pass == 0);
          default: tick(0, 0, 0, 1, 0);
        endcase
        n_checks++;
        if ({Count, Busy, Done} !== exp[i]) begin
          n_fail++;
          $display("[TB] FAIL abort_reset pass %0d step %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                   pass, i, Count, Busy, Done, exp[i][5:2], exp[i][1], exp[i][0]);
        end
      end
    end
  endtask

  task automatic test_load_priority();
    logic [5:0] exp [7];
    exp = '{{4'd6, 1'b1, 1'b0}, {4'd5, 1'b1, 1'b0}, {4'd4, 1'b1, 1'b0}, {4'd9, 1'b1, 1'b0},
            {4'd0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: tick(0, 1, 6, 0, 0);
        1, 2: tick(0, 0, 0, 1, 0);
        3: tick(0, 1, 9, 1, 0);
        4: tick(0, 1, 0, 1, 0);
        5: tick(0, 0, 0, 1, 0);
        default: tick(0, 1, 7, 1, 1);
      endcase
      n_checks++;
      if ({Count, Busy, Done} !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL load_priority step %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, exp[i][5:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_reload();
    logic [5:0] exp [8];
`ifdef COUNTDOWN_AUTORELOAD_EN
    exp = '{{4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b0},
            {4'd1, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b0}};
`else
    exp = '{{4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0},
            {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
`endif
    for (int i = 0; i < 8; i++) begin
      if (i == 0) tick(0, 1, 2, 0, 0);
      else tick(0, 0, 0, 1, i == 7);
      n_checks++;
      if ({Count, Busy, Done} !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL reload step %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, exp[i][5:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  // Full-scale load with Decrease held well past expiry: Count must stick at 0 and Done fire once.
  task automatic test_no_wrap();
    int done_seen = 0;
    int exp_count;
    bit exp_busy;
    bit exp_done;
    tick(0, 1, 15, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 1, 0);
      if (Done === 1'b1) done_seen++;
`ifdef COUNTDOWN_AUTORELOAD_EN
      exp_count = m_count;
      exp_busy = (m_phase == PH_RUN);
      exp_done = (m_phase == PH_EXPIRED);
`else
      exp_count = (i < 15) ? 15 - i : 0;
      exp_busy = (i < 15);
      exp_done = (i == 15);
`endif
      n_checks++;
      if ({Count, Busy, Done} !== {WIDTH'(exp_count), exp_busy, exp_done}) begin
        n_fail++;
        $display("[TB] FAIL no_wrap cycle %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, exp_count, exp_busy, exp_done);
      end
    end
    n_checks++;
    if (done_seen != 1) begin
      n_fail++;
      $display("[TB] FAIL no_wrap done_pulses: got %0d, expected 1", done_seen);
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit rst, ld, dec, ab;
    int lv;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      ab = ($urandom_range(0, 19) == 0);
      ld = ($urandom_range(0, 5) == 0);
      dec = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) lv = int'($urandom_range(0, 15));
      tick(rst, ld, lv, dec, ab);
      n_checks++;
      if ({Count, Busy, Done} !== {WIDTH'(m_count), m_phase == PH_RUN, m_phase == PH_EXPIRED}) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got Count=%0d Busy=%0b Done=%0b, expected Count=%0d Busy=%0b Done=%0b",
                 i, Count, Busy, Done, m_count, m_phase == PH_RUN, m_phase == PH_EXPIRED);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Load = 1'b0;
    LoadValue = '0;
    Decrease = 1'b0;
    Abort = 1'b0;
    test_reset();
    test_decrease_held();
    test_decrease_toggle();
    test_abort_and_reset();
    test_load_priority();
    test_reload();
    test_no_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bit width of LoadValue and Count.
REQ-002 SHALL have port: Clock  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Load  input  1  one-cycle strobe; capture LoadValue and start the countdown.
REQ-005 SHALL have port: LoadValue  input  WIDTH  start value, sampled only when Load=1.
REQ-006 SHALL have port: Decrease  input  1  tick enable; decrement Count by one per cycle while high in RUN.
REQ-007 SHALL have port: Abort  input  1  cancel the countdown; return to IDLE.
REQ-008 SHALL have port: Count  output  WIDTH  current remaining value, registered.
REQ-009 SHALL have port: Busy  output  1  high while state=RUN.
REQ-010 SHALL have port: Done  output  1  high for exactly one cycle, while state=EXPIRED.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, EXPIRED; all outputs decode from registered state and Count only.
REQ-012 SHALL apply input priority per edge: Reset > Abort > Load > Decrease.
REQ-013 SHALL, on Abort in any state: next state IDLE, Count<=0.
REQ-014 SHALL, on Load in any state with LoadValue!=0: Count<=LoadValue, next state RUN; Decrease is ignored that edge.
REQ-015 SHALL, on Load with LoadValue=0: Count<=0, next state EXPIRED (Done one cycle later).
REQ-016 SHALL, in RUN with Decrease=1 and Count>1: Count<=Count-1, state stays RUN.
REQ-017 SHALL, in RUN with Decrease=1 and Count=1: Count<=0, next state EXPIRED.
REQ-018 SHALL, in RUN with Decrease=0: hold Count and state.
REQ-019 SHALL ignore Decrease in IDLE and EXPIRED; Count never wraps below 0.
REQ-020 SHALL leave EXPIRED after exactly one cycle, unless Load or Abort is asserted (see REQ-012..015); the destination is defined under Configuration.
REQ-021 SHALL hold Count and stay in IDLE when no input is active.
REQ-022 SHALL have a latency of one edge: Load to Busy=1 and Count=LoadValue; final Decrease to Done=1.

Reset
REQ-023 SHALL, on Reset=1 at a rising Clock edge, set state=IDLE, Count=0, Busy=0, Done=0, reload register=0, regardless of other inputs or the current state.
REQ-024 SHALL, when Reset is asserted mid-countdown, discard the pending count without asserting Done.

Configuration
REQ-025 SHALL use macro COUNTDOWN_AUTORELOAD_EN to select the auto-reload feature.
REQ-026 SHALL, with COUNTDOWN_AUTORELOAD_EN defined: capture LoadValue into a WIDTH-bit reload register on every Load; EXPIRED goes next to RUN with Count<=reload value if it is nonzero, otherwise to IDLE with Count=0.
REQ-027 SHALL, without COUNTDOWN_AUTORELOAD_EN: omit the reload register; EXPIRED goes next to IDLE with Count=0.

Verification
REQ-028 SHALL cover: Reset then Load=1, LoadValue=3, then Decrease held high -> Count 3,2,1,0 on consecutive edges; Done=1 for one cycle when Count=0; Busy=0 after.
REQ-029 SHALL cover: LoadValue=5 with Decrease toggled 1,0,1,0 -> Count 5,4,4,3,3; Busy=1 throughout.
REQ-030 SHALL cover: Abort while Count=2 in RUN -> next edge IDLE, Count=0, no Done pulse; same for Reset.
REQ-031 SHALL cover: Load with LoadValue=9 and Decrease in the same cycle while Count=4 -> Count=9 (Load wins); Load with LoadValue=0 -> Done pulse on the next cycle.
REQ-032 SHALL cover (macro defined): LoadValue=2 with Decrease held -> Count 2,1,0(Done),2,1,0(Done) repeating until Abort; (macro undefined): single Done, then IDLE.
REQ-033 SHALL cover: WIDTH=4, LoadValue=15 with Decrease held for 20 cycles -> exactly one Done, Count held at 0, no wrap to 15 (macro undefined).
